mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the shared 256 x 16 word memory. It accepts read/write requests from two requesters (instruction fetch on port 0, data access on port 1). It serialises them onto the single memory port (read strobe, write strobe, 8-bit address, 16-bit data in/out, ready), captures read data, and returns a one-cycle acknowledge or timeout error to the granted requester. It sits between the controller/datapath and the memory.

---
 rtl/mem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared state encoding and default sizes for the shared-memory arbiter.
package mem_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the port that was not served last.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic gnt_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    gnt_o   = (req0_i & req1_i) ? ~last_i : req1_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises two requesters onto the single memory port and returns ack/err pulses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              gntValid, gntPort, capture;

  rr_arb2 u_arb (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_q),
    .valid_o (gntValid),
    .gnt_o   (gntPort)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes are computed one cycle ahead so every memory-side output comes from a flop.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = 1'b0;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gntValid) begin
          port_d  = gntPort;
          last_d  = gntPort;
          we_d    = gntPort ? we1 : we0;
          addr_d  = gntPort ? addr1 : addr0;
          wdata_d = gntPort ? wdata1 : wdata0;
          rd_d    = ~we_d;
          wr_d    = we_d;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = WAIT;
        end else if (mem_rdy) begin
          capture = 1'b1;
          rd_d    = 1'b0;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rdy) begin
          capture = ~we_q;
          rd_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rd_d    = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      if (port_q) rdata1_d = mem_rdata;
      else        rdata0_d = mem_rdata;
    end
  end

  assign busy      = (state_q != IDLE);
  assign ack0      = (state_q == RESP) & ~err_q & ~port_q;
  assign ack1      = (state_q == RESP) & ~err_q &  port_q;
  assign err0      = (state_q == RESP) &  err_q & ~port_q;
  assign err1      = (state_q == RESP) &  err_q &  port_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences, then random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reqV = '0;
  logic [1:0]  weV = '0;
  logic [7:0]  addrV [2];
  logic [15:0] wdataV [2];
  logic        ack0, ack1, err0, err1, busy, memRead, memWrite, memRdy;
  logic [15:0] rdata0, rdata1, memWdata, memRdata;
  logic [7:0]  memAddr;

  logic [15:0] memArr [256];
  logic        preload = 1'b1;
  int          busyAge = 0;
  int          rdyDelay = 0;
  logic        rdyRandom = 1'b0;
  logic        rdyRandBit = 1'b1;

  int checks = 0;
  int passes = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (reqV[0]),
    .req1      (reqV[1]),
    .we0       (weV[0]),
    .we1       (weV[1]),
    .addr0     (addrV[0]),
    .addr1     (addrV[1]),
    .wdata0    (wdataV[0]),
    .wdata1    (wdataV[1]),
    .ack0      (ack0),
    .ack1      (ack1),
    .err0      (err0),
    .err1      (err1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .busy      (busy),
    .mem_read  (memRead),
    .mem_write (memWrite),
    .mem_addr  (memAddr),
    .mem_wdata (memWdata),
    .mem_rdy   (memRdy),
    .mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] initPattern(input int a);
    logic [7:0] b;
    b = 8'(a);
    return (a == 5) ? 16'h1234 : {b, ~b};
  endfunction

  // Memory model: ready either after a fixed delay from the start of a transaction or randomly.
  assign memRdy   = rdyRandom ? rdyRandBit : (busyAge >= rdyDelay);
  assign memRdata = memRdy ? memArr[memAddr] : 16'hzzzz;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) memArr[i] <= initPattern(i);
    end else if (memWrite) begin
      memArr[memAddr] <= memWdata;
    end
    busyAge <= busy ? busyAge + 1 : 0;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation stuck");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One transaction on port p; counts cycles from request to its response pulse.
  task automatic applyStimulus(input logic p, input logic we, input logic [7:0] addr,
                               input logic [15:0] wdata, input int delay,
                               output int lat, output logic gotAck, output logic gotErr,
                               output int stray, output int wrCycles, output int wrBad);
    rdyDelay  = delay;
    weV[p]    = we;
    addrV[p]  = addr;
    wdataV[p] = wdata;
    reqV[p]   = 1'b1;
    lat = 0; gotAck = 1'b0; gotErr = 1'b0; stray = 0; wrCycles = 0; wrBad = 0;
    while (!(gotAck || gotErr) && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (memWrite) begin
        wrCycles++;
        if (memAddr !== addr || memWdata !== wdata) wrBad++;
      end
      gotAck = p ? ack1 : ack0;
      gotErr = p ? err1 : err0;
      if (p ? (ack0 | err0) : (ack1 | err1)) stray++;
    end
    reqV[p] = 1'b0;
    @(posedge clk); @(negedge clk);
    if (ack0 | ack1 | err0 | err1) stray++;
  endtask

  // Both ports request continuously; completions must alternate starting with firstPort.
  task automatic applyContention(input string tag, input logic firstPort, input int n,
                                 input logic [7:0] a0, input logic [7:0] a1, output logic lastPort);
    int got;
    logic expPort;
    logic [15:0] exp0, exp1;
    exp0 = initPattern(int'(a0));
    exp1 = initPattern(int'(a1));
    weV = 2'b00; addrV[0] = a0; addrV[1] = a1; rdyDelay = 0; rdyRandom = 1'b0;
    reqV = 2'b11;
    expPort = firstPort;
    got = 0;
    for (int c = 0; c < 60 && got < n; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack0 | ack1 | err0 | err1) begin
        checkOutput($sformatf("%s ack order %0d", tag, got), {30'd0, ack1, ack0}, expPort ? 32'd2 : 32'd1);
        checkOutput($sformatf("%s err %0d", tag, got), {30'd0, err1, err0}, 32'd0);
        checkOutput($sformatf("%s rdata %0d", tag, got), expPort ? rdata1 : rdata0, expPort ? exp1 : exp0);
        expPort = ~expPort;
        got++;
      end
    end
    reqV = 2'b00;
    checkOutput($sformatf("%s completions", tag), got, n);
    lastPort = ~expPort;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          delay;
    logic        expErr;
    logic [15:0] expRdata;
    int          expLat;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] modelMem [256];
  logic [15:0] expRd [2];
  logic        pending [2];
  int          raiseCyc [2];
  int          gap [2];

  task automatic startTxn(input int p, input int cyc);
    weV[p]    = 1'($urandom_range(0, 1));
    addrV[p]  = 8'($urandom_range(8, 23));
    wdataV[p] = 16'($urandom);
    reqV[p]   = 1'b1;
    pending[p]  = 1'b1;
    raiseCyc[p] = cyc;
  endtask

  initial begin
    int lat, stray, wrCycles, wrBad, cnt;
    logic gotAck, gotErr, lastServed;
    int ackCnt, errCnt, otherCnt, wrCnt;
    int cyc, prevAckCyc, completions, prevPort;
    logic havePrev, stalled, done, isErr;

    //       port  we    addr   wdata     dly err   rdata     lat
    vecs[0]  = '{1'b0, 1'b0, 8'h05, 16'h0000, 0,  1'b0, 16'h1234, 2};
    vecs[1]  = '{1'b1, 1'b1, 8'h80, 16'hBEEF, 0,  1'b0, 16'h0000, 3};
    vecs[2]  = '{1'b0, 1'b0, 8'h80, 16'h0000, 0,  1'b0, 16'hBEEF, 2};
    vecs[3]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 3,  1'b0, 16'h10EF, 5};
    vecs[4]  = '{1'b0, 1'b1, 8'h10, 16'hCAFE, 5,  1'b0, 16'hBEEF, 7};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 1,  1'b0, 16'hCAFE, 3};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 14, 1'b0, 16'hFF00, 16};
    vecs[7]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 99, 1'b1, 16'hFF00, 17};
    vecs[8]  = '{1'b1, 1'b1, 8'h21, 16'h5555, 99, 1'b1, 16'hCAFE, 17};
    vecs[9]  = '{1'b1, 1'b0, 8'h21, 16'h0000, 0,  1'b0, 16'h5555, 2};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 16'h0000, 2,  1'b0, 16'h00FF, 4};

    for (int i = 0; i < 256; i++) modelMem[i] = initPattern(i);
    addrV[0] = '0; addrV[1] = '0; wdataV[0] = '0; wdataV[1] = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset strobes", {25'd0, busy, memRead, memWrite, ack0, ack1, err0, err1}, 32'd0);
    checkOutput("reset mem_addr", memAddr, 32'd0);
    checkOutput("reset mem_wdata", memWdata, 32'd0);
    checkOutput("reset rdata0", rdata0, 32'd0);
    checkOutput("reset rdata1", rdata1, 32'd0);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
                    lat, gotAck, gotErr, stray, wrCycles, wrBad);
      checkOutput($sformatf("vec%0d ack", i), gotAck, !vecs[i].expErr);
      checkOutput($sformatf("vec%0d err", i), gotErr, vecs[i].expErr);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d rdata", i), vecs[i].port ? rdata1 : rdata0, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d stray response", i), stray, 32'd0);
      checkOutput($sformatf("vec%0d write strobes", i), wrCycles, vecs[i].we ? 32'd1 : 32'd0);
      checkOutput($sformatf("vec%0d write addr/data", i), wrBad, 32'd0);
      if (vecs[i].we) modelMem[vecs[i].addr] = vecs[i].wdata;
    end
    lastServed = vecs[10].port;

    applyContention("alt", ~lastServed, 4, 8'h30, 8'h31, lastServed);

    // Port 1 drops its request right after the grant and scribbles its inputs.
    weV[1] = 1'b1; addrV[1] = 8'h40; wdataV[1] = 16'h7777; rdyDelay = 0;
    reqV[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    reqV[1] = 1'b0; addrV[1] = 8'h41; wdataV[1] = 16'h0000;
    ackCnt = 0; errCnt = 0; otherCnt = 0; wrCnt = memWrite ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      ackCnt += ack1 ? 1 : 0;
      errCnt += err1 ? 1 : 0;
      otherCnt += (ack0 | err0) ? 1 : 0;
      wrCnt += memWrite ? 1 : 0;
    end
    checkOutput("drop ack1 pulses", ackCnt, 32'd1);
    checkOutput("drop err1 pulses", errCnt, 32'd0);
    checkOutput("drop port0 responses", otherCnt, 32'd0);
    checkOutput("drop write strobes", wrCnt, 32'd1);
    checkOutput("drop mem[0x40]", memArr[8'h40], 32'h7777);
    checkOutput("drop mem[0x41]", memArr[8'h41], 32'h41BE);
    checkOutput("drop idle", busy, 32'd0);
    modelMem[8'h40] = 16'h7777;

    // Reset while a read sits in WAIT.
    weV[0] = 1'b0; addrV[0] = 8'h50; rdyDelay = 99;
    reqV[0] = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midwait busy", {30'd0, busy, memRead}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset strobes", {25'd0, busy, memRead, memWrite, ack0, ack1, err0, err1}, 32'd0);
    checkOutput("midreset mem_addr", memAddr, 32'd0);
    checkOutput("midreset rdata0", rdata0, 32'd0);
    checkOutput("midreset rdata1", rdata1, 32'd0);
    reqV[0] = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += (ack0 | ack1 | err0 | err1 | busy) ? 1 : 0;
    end
    checkOutput("midreset quiet", cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    applyContention("posttie", 1'b0, 2, 8'h60, 8'h61, lastServed);

    // Random traffic against a transaction-level model of memory and fairness.
    expRd[0] = initPattern(8'h60);
    expRd[1] = initPattern(8'h61);
    rdyRandom = 1'b1; rdyRandBit = 1'b1;
    cyc = 0; prevAckCyc = 0; prevPort = 0; completions = 0;
    havePrev = 1'b0; stalled = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pending[p] = 1'b0; gap[p] = p; raiseCyc[p] = 0;
    end
    for (int c = 0; c < 2500 && !stalled; c++) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        done  = p ? (ack1 | err1) : (ack0 | err0);
        isErr = p ? err1 : err0;
        if (done) begin
          checkOutput($sformatf("rand p%0d response while requesting", p), pending[p], 32'd1);
          if (weV[p]) modelMem[addrV[p]] = wdataV[p];
          else if (!isErr) expRd[p] = modelMem[addrV[p]];
          checkOutput($sformatf("rand p%0d rdata", p), p ? rdata1 : rdata0, expRd[p]);
          if (havePrev && pending[1 - prevPort] && raiseCyc[1 - prevPort] <= prevAckCyc + 1)
            checkOutput("rand round-robin port", p, 1 - prevPort);
          prevPort = p; prevAckCyc = cyc; havePrev = 1'b1;
          completions++;
          pending[p] = 1'b0;
          if ($urandom_range(0, 1) == 1) startTxn(p, cyc);
          else begin
            reqV[p] = 1'b0;
            gap[p] = $urandom_range(0, 3);
          end
        end else if (!pending[p]) begin
          if (gap[p] == 0) startTxn(p, cyc);
          else gap[p]--;
        end else if (cyc - raiseCyc[p] > 100) begin
          checks++;
          $display("[TB] FAIL rand p%0d wait: %0d cycles, required at most 100", p, cyc - raiseCyc[p]);
          stalled = 1'b1;
        end
      end
      rdyRandBit = ($urandom_range(0, 3) != 0);
    end
    reqV = 2'b00;
    rdyRandBit = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("rand progress", completions > 100, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
